// File: rtl/npu_mac_pkg.sv
// Shared types and helpers for the NPU MAC datapath: the systolic tile FSM
// state encoding, default operand/accumulator widths and a product
// sign-extension helper used by every processing element.
package npu_mac_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  // Widest intermediate the sign-extension helper works in.
  localparam int EXT_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } mac_state_e;

  // Sign-extend a prod_w-bit two's-complement product (right-aligned in a
  // zero-padded EXT_W word) to the full EXT_W width.
  function automatic logic signed [EXT_W-1:0] sext_prod(input logic [EXT_W-1:0] prod,
                                                         input int unsigned      prod_w);
    logic signed [EXT_W-1:0] tmp;
    tmp = $signed(prod << (EXT_W - prod_w));
    return tmp >>> (EXT_W - prod_w);
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// Operand-in / result-out bus of the systolic MAC tile. The slave modport is
// the tile's view; the master modport is the operand buffer / writeback side.
interface systolic_mac_array_if
  import npu_mac_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = 12
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                    start;
  logic [K_W-1:0]          k_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [ROWS*DATA_W-1:0]  a_vec;
  logic [COLS*DATA_W-1:0]  b_vec;
  logic                    out_valid;
  logic                    out_ready;
  logic [ROW_W-1:0]        out_row;
  logic [COLS*ACC_W-1:0]   out_data;
  logic                    busy;
  logic                    done;
  logic                    sat_flag;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_data, busy, done, sat_flag
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_data, busy, done, sat_flag
  );

endinterface

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards A right and B down with
// their tokens, and accumulates a*b when both incoming tokens are set.
// Saturating accumulation and the sticky clip bit exist only when
// SYSTOLIC_MAC_SAT_EN is defined; otherwise the accumulator wraps.
module systolic_pe
  import npu_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              a_tok_in,
  input  logic              b_tok_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              a_tok_out,
  output logic              b_tok_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              sat_out
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic [EXT_W-1:0]           prod_wide_s;
  logic signed [EXT_W-1:0]    prod_sx_s;
  logic [EXT_W-ACC_W-1:0]     sx_hi_unused_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic signed [ACC_W-1:0]    acc_d, acc_q;
  logic                       sat_d, sat_q;
  logic [DATA_W-1:0]          a_q, b_q;
  logic                       a_tok_q, b_tok_q;
`ifdef SYSTOLIC_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0]      sum_s;
`endif

  assign prod_s      = $signed(a_in) * $signed(b_in);
  assign prod_wide_s = {{(EXT_W-2*DATA_W){1'b0}}, prod_s};
  assign prod_sx_s   = sext_prod(prod_wide_s, 2*DATA_W);
  assign {sx_hi_unused_s, prod_ext_s} = prod_sx_s;
`ifdef SYSTOLIC_MAC_SAT_EN
  assign sum_s = {acc_q[ACC_W-1], acc_q} + {prod_ext_s[ACC_W-1], prod_ext_s};
`endif

  // Next accumulator / sticky value: clear on tile start, MAC on a token.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (a_tok_in && b_tok_in) begin
`ifdef SYSTOLIC_MAC_SAT_EN
      if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
        acc_d = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
        sat_d = sat_q;
      end
`else
      acc_d = acc_q + prod_ext_s;
      sat_d = 1'b0;
`endif
    end else begin
      acc_d = acc_q;
      sat_d = sat_q;
    end
  end

  // Pass-through pipeline registers and the accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_tok_q <= 1'b0;
      b_tok_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      a_q     <= a_in;
      b_q     <= b_in;
      a_tok_q <= a_tok_in;
      b_tok_q <= b_tok_in;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign a_tok_out = a_tok_q;
  assign b_tok_out = b_tok_q;
  assign acc_out   = acc_q;
  assign sat_out   = sat_q;

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary ROWSxCOLS systolic GEMM tile: input skew lanes, the PE
// grid, the IDLE/LOAD/FLUSH/DRAIN sequencer and the registered row drain mux.
// Optional feature macro: SYSTOLIC_MAC_SAT_EN (saturating accumulate, sat_flag).
module systolic_mac_array
  import npu_mac_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  systolic_mac_array_if.slave  bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL_W  = $clog2(ROWS + COLS);
  localparam int LANES = ROWS + COLS;
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ROWS + COLS - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  mac_state_e             state_d, state_q;
  logic [K_W-1:0]         k_len_d, k_len_q, beat_cnt_d, beat_cnt_q;
  logic [FL_W-1:0]        flush_cnt_d, flush_cnt_q;
  logic [ROW_W-1:0]       row_d, row_q, row_nxt_s;
  logic [COLS*ACC_W-1:0]  out_data_d, out_data_q;
  logic                   in_ready_d, in_ready_q, busy_d, busy_q;
  logic                   out_valid_d, out_valid_q, done_d, done_q;
  logic                   sat_flag_d, sat_flag_q;
  logic                   beat_s, clr_s;

  logic [DATA_W-1:0]      lane_out_s [LANES];
  logic                   lane_tok_s [LANES];
  logic [DATA_W-1:0]      a_h [ROWS][COLS];
  logic                   at_h [ROWS][COLS];
  logic [DATA_W-1:0]      b_v [ROWS][COLS];
  logic                   bt_v [ROWS][COLS];
  logic [ACC_W-1:0]       acc_s [ROWS][COLS];
  logic [ROWS*COLS-1:0]   sat_s;
  logic [COLS*ACC_W-1:0]  row_data_s [ROWS];

  assign beat_s    = bus.in_valid & in_ready_q;
  assign clr_s     = bus.start & (state_q == ST_IDLE);
  assign row_nxt_s = row_q + ROW_W'(1);

  // Skew lanes: lanes 0..ROWS-1 carry A row i (delay i), the rest B column j (delay j).
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int DLY = (l < ROWS) ? l : l - ROWS;
    logic [DATA_W-1:0] lane_in_s;
    if (l < ROWS) begin : g_a
      assign lane_in_s = bus.a_vec[l*DATA_W +: DATA_W];
    end else begin : g_b
      assign lane_in_s = bus.b_vec[(l-ROWS)*DATA_W +: DATA_W];
    end
    if (DLY == 0) begin : g_direct
      assign lane_out_s[l] = lane_in_s;
      assign lane_tok_s[l] = beat_s;
    end else begin : g_dly
      logic [DATA_W-1:0] sk_d [DLY];
      logic [DATA_W-1:0] sk_q [DLY];
      logic              tk_d [DLY];
      logic              tk_q [DLY];
      // Shift the new beat (or a token-clear bubble) into the delay line.
      always_comb begin
        sk_d[0] = lane_in_s;
        tk_d[0] = beat_s;
        for (int s = 1; s < DLY; s++) begin
          sk_d[s] = sk_q[s-1];
          tk_d[s] = tk_q[s-1];
        end
      end
      // Delay-line registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < DLY; s++) begin
            sk_q[s] <= '0;
            tk_q[s] <= 1'b0;
          end
        end else begin
          sk_q <= sk_d;
          tk_q <= tk_d;
        end
      end
      assign lane_out_s[l] = sk_q[DLY-1];
      assign lane_tok_s[l] = tk_q[DLY-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_left
    assign a_h[i][0]  = lane_out_s[i];
    assign at_h[i][0] = lane_tok_s[i];
  end
  for (genvar j = 0; j < COLS; j++) begin : g_top
    assign b_v[0][j]  = lane_out_s[ROWS+j];
    assign bt_v[0][j] = lane_tok_s[ROWS+j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [DATA_W-1:0] a_o_s, b_o_s;
      logic              at_o_s, bt_o_s;
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .rst_n(rst_n), .clr(clr_s),
        .a_in(a_h[i][j]), .b_in(b_v[i][j]), .a_tok_in(at_h[i][j]), .b_tok_in(bt_v[i][j]),
        .a_out(a_o_s), .b_out(b_o_s), .a_tok_out(at_o_s), .b_tok_out(bt_o_s),
        .acc_out(acc_s[i][j]), .sat_out(sat_s[i*COLS+j])
      );
      if (j < COLS - 1) begin : g_right
        assign a_h[i][j+1]  = a_o_s;
        assign at_h[i][j+1] = at_o_s;
      end else begin : g_redge
        logic [DATA_W:0] a_edge_unused_s;
        assign a_edge_unused_s = {at_o_s, a_o_s};
      end
      if (i < ROWS - 1) begin : g_down
        assign b_v[i+1][j]  = b_o_s;
        assign bt_v[i+1][j] = bt_o_s;
      end else begin : g_bedge
        logic [DATA_W:0] b_edge_unused_s;
        assign b_edge_unused_s = {bt_o_s, b_o_s};
      end
      assign row_data_s[i][j*ACC_W +: ACC_W] = acc_s[i][j];
    end
  end

`ifndef SYSTOLIC_MAC_SAT_EN
  logic sat_unused_s;
  assign sat_unused_s = |sat_s;
`endif

  // Sequencer next state, counters, drain mux and registered outputs.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_len_d     = bus.k_len;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          row_d       = '0;
          state_d     = (bus.k_len == K_W'(0)) ? ST_FLUSH : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (beat_s) begin
          beat_cnt_d = beat_cnt_q + K_W'(1);
          state_d    = (beat_cnt_d == k_len_q) ? ST_FLUSH : ST_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FL_LAST) begin
          state_d    = ST_DRAIN;
          row_d      = '0;
          out_data_d = row_data_s[0];
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d      = row_nxt_s;
            out_data_d = row_data_s[row_nxt_s];
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_DRAIN);
`ifdef SYSTOLIC_MAC_SAT_EN
    if (clr_s) begin
      sat_flag_d = 1'b0;
    end else begin
      sat_flag_d = |sat_s;
    end
`else
    sat_flag_d = 1'b0;
`endif
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = row_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
  assign bus.sat_flag  = sat_flag_q;

endmodule
